mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory stage: computes the effective address, runs the data-memory handshake and aligns load data.
// Ports: mem_bus_i/in_valid/in_ready from ALU, mem_bus_o/out_valid/out_ready to writeback, dmem_* bus, stall and exception flags.
package core;
   typedef enum logic [3:0] {
      MEM_NOP,
      MEM_LB,
      MEM_LH,
      MEM_LW,
      MEM_LBU,
      MEM_LHU,
      MEM_SB,
      MEM_SH,
      MEM_SW
   } mem_op_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      mem_op_t     mem_op;
      logic [4:0]  rd;
      logic [31:0] rd_res;
      logic        rf_wr_en;
      logic        pipeline_stall;
   } pipeline_bus_t;
endpackage

module mem_stage
   import core::*;
#(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  pipeline_bus_t mem_bus_i,
   input  logic          in_valid,
   output logic          in_ready,
   output pipeline_bus_t mem_bus_o,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [31:0]   dmem_addr,
   output logic [3:0]    dmem_be,
   output logic [31:0]   dmem_wdata,
   input  logic          dmem_gnt,
   input  logic          dmem_rvalid,
   input  logic [31:0]   dmem_rdata,
   output logic          stall_o,
   output logic          misaligned_o,
   output logic          timeout_o
);

   localparam int CW = $clog2(TIMEOUT_CYC) + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          cnt_last;

   pipeline_bus_t bus_q, res_q;
   logic [31:0]   ea_q, wdata_q;
   logic [3:0]    be_q;
   logic          we_q;
   logic          ov_q, mis_q, tmo_q;

   logic          acc, is_nop, is_st, is_half, is_word, mis;
   logic [31:0]   ea, wd;
   logic [3:0]    be;
   logic [31:0]   lane, ld;

   // decode of the incoming instruction
   always_comb begin
      ea      = mem_bus_i.rs1_data + mem_bus_i.imm;
      is_nop  = (mem_bus_i.mem_op == MEM_NOP);
      is_st   = mem_bus_i.mem_op inside {MEM_SB, MEM_SH, MEM_SW};
      is_half = mem_bus_i.mem_op inside {MEM_LH, MEM_LHU, MEM_SH};
      is_word = mem_bus_i.mem_op inside {MEM_LW, MEM_SW};
      mis     = (is_half && ea[0]) || (is_word && (ea[1:0] != 2'b00));
      be      = 4'b1111;
      wd      = mem_bus_i.rs2_data;
      if (is_half) begin
         be = 4'b0011 << ea[1:0];
         wd = {2{mem_bus_i.rs2_data[15:0]}};
      end else if (!is_word) begin
         be = 4'b0001 << ea[1:0];
         wd = {4{mem_bus_i.rs2_data[7:0]}};
      end
   end

   // load lane alignment and extension
   always_comb begin
      lane = dmem_rdata >> {ea_q[1:0], 3'b000};
      unique case (bus_q.mem_op)
         MEM_LB:  ld = {{24{lane[7]}}, lane[7:0]};
         MEM_LBU: ld = {24'h0, lane[7:0]};
         MEM_LH:  ld = {{16{lane[15]}}, lane[15:0]};
         MEM_LHU: ld = {16'h0, lane[15:0]};
         default: ld = lane;
      endcase
   end

   assign in_ready   = (state_q == IDLE) && (!ov_q || out_ready);
   assign acc        = in_valid && in_ready;
   assign stall_o    = (state_q != IDLE) || (ov_q && !out_ready);
   assign cnt_last   = (cnt_q == CW'(TIMEOUT_CYC - 1));

   assign dmem_req   = (state_q == REQ);
   assign dmem_we    = dmem_req && we_q;
   assign dmem_be    = dmem_req ? be_q : 4'b0000;
   assign dmem_addr  = {ea_q[31:2], 2'b00};
   assign dmem_wdata = wdata_q;

   assign out_valid    = ov_q;
   assign misaligned_o = mis_q;
   assign timeout_o    = tmo_q;

   always_comb begin
      mem_bus_o = res_q;
      mem_bus_o.pipeline_stall = stall_o;
   end

   // NOPs and misaligned ops complete straight from IDLE so they
   // can stream one per cycle; DONE holds memory results only.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (acc && !is_nop && !mis)
               state_d = REQ;
         end
         REQ: begin
            if (dmem_gnt)
               state_d = we_q ? DONE : WAIT_R;
            else if (cnt_last)
               state_d = DONE;
         end
         WAIT_R: begin
            if (dmem_rvalid || cnt_last)
               state_d = DONE;
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            cnt_q <= '0;
         else if (state_q == REQ || state_q == WAIT_R)
            cnt_q <= cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus_q   <= '0;
         ea_q    <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         res_q   <= '0;
         ov_q    <= 1'b0;
         mis_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         if (acc) begin
            bus_q   <= mem_bus_i;
            ea_q    <= ea;
            wdata_q <= wd;
            be_q    <= be;
            we_q    <= is_st;
         end
         if (ov_q && out_ready)
            ov_q <= 1'b0;
         unique case (1'b1)
            acc && (is_nop || mis): begin
               res_q          <= mem_bus_i;
               res_q.rf_wr_en <= is_nop && mem_bus_i.rf_wr_en;
               ov_q           <= 1'b1;
               mis_q          <= mis;
               tmo_q          <= 1'b0;
            end
            (state_q == REQ) && dmem_gnt && we_q: begin
               res_q          <= bus_q;
               res_q.rf_wr_en <= 1'b0;
               ov_q           <= 1'b1;
               mis_q          <= 1'b0;
               tmo_q          <= 1'b0;
            end
            (state_q == REQ) && !dmem_gnt && cnt_last,
            (state_q == WAIT_R) && !dmem_rvalid && cnt_last: begin
               res_q          <= bus_q;
               res_q.rf_wr_en <= 1'b0;
               ov_q           <= 1'b1;
               mis_q          <= 1'b0;
               tmo_q          <= 1'b1;
            end
            (state_q == WAIT_R) && dmem_rvalid: begin
               res_q          <= bus_q;
               res_q.rd_res   <= ld;
               res_q.rf_wr_en <= (bus_q.rd != 5'd0);
               ov_q           <= 1'b1;
               mis_q          <= 1'b0;
               tmo_q          <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
